// File: rtl/alu32_issue_queue.sv
// alu32_issue_queue
// Command FIFO plus registered result stage in front of a purely
// combinational 32-bit ALU. Commands enter over a valid/ready handshake,
// issue one per cycle to the ALU, and the 33-bit result is held in a
// result register that drains over a second valid/ready handshake.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready are both high; valid never depends on ready, and
// cmd_ready depends only on the FIFO being full (no write-through).
//
// Optional feature macro: ALU_DIVZ_TRAP_EN
//   defined   - divide with operand 2 == 0 is trapped instead of issued and
//               returns 33'h1_FFFF_FFFF with divz_err set.
//   undefined - divide-by-zero issues normally; divz_err is tied low.
module alu32_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        alu_en,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [32:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [32:0] res_data,
    output logic [4:0]  res_op,
    output logic        divz_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [4:0] OP_DIV = 5'b00101;

    // Entry layout: {op[4:0], a[31:0], b[31:0]}
    logic [68:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          r_res_valid;
    logic [32:0]   r_res_data;
    logic [4:0]    r_res_op;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_trap;
    logic          w_op_defined;
    logic [4:0]    w_head_op;
    logic [31:0]   w_head_a;
    logic [31:0]   w_head_b;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    // Pop whenever a head exists and the result register is free or draining.
    assign w_pop     = !w_empty && (!r_res_valid || res_ready);

    assign w_head_op = r_mem[r_rptr][68:64];
    assign w_head_a  = r_mem[r_rptr][63:32];
    assign w_head_b  = r_mem[r_rptr][31:0];

`ifdef ALU_DIVZ_TRAP_EN
    assign w_trap = (w_head_op == OP_DIV) && (w_head_b == 32'd0);
`else
    assign w_trap = 1'b0;
`endif

    // Decode the defined opcode set; anything else yields a zero result.
    always_comb begin
        w_op_defined = 1'b0;
        case (w_head_op)
            5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
            5'b00011, 5'b11000, 5'b00110, 5'b00101, 5'b01010: w_op_defined = 1'b1;
            default:                                           w_op_defined = 1'b0;
        endcase
    end

    // Drive the ALU only in issue cycles; zeros otherwise keep it quiet.
    always_comb begin
        alu_en  = 1'b0;
        alu_op  = 5'd0;
        alu_in1 = 32'd0;
        alu_in2 = 32'd0;
        if (w_pop && !w_trap) begin
            alu_en  = 1'b1;
            alu_op  = w_head_op;
            alu_in1 = w_head_a;
            alu_in2 = w_head_b;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result register: loads on issue, empties when consumed without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= 33'd0;
            r_res_op    <= 5'd0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_op    <= w_head_op;
            if (w_trap)            r_res_data <= 33'h1_FFFF_FFFF;
            else if (w_op_defined) r_res_data <= alu_out;
            else                   r_res_data <= 33'd0;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef ALU_DIVZ_TRAP_EN
    logic r_divz;

    // Error flag travels with the result register contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divz <= 1'b0;
        end else if (w_pop) begin
            r_divz <= w_trap;
        end else if (r_res_valid && res_ready) begin
            r_divz <= 1'b0;
        end
    end

    assign divz_err = r_divz;
`else
    assign divz_err = 1'b0;
`endif

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;

endmodule

// File: tb/tb_alu32_issue_queue.sv
// Bench for alu32_issue_queue: table of hand-computed single-command
// vectors, then back-pressure, streaming and mid-operation reset sequences.
// Inputs change #1 after a rising edge; outputs are sampled on falling edges.
module tb_alu32_issue_queue;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [32:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [32:0] res_data;
  logic [4:0]  res_op;
  logic        divz_err;

  int n_chk;
  int n_fail;

  // expected result record: {divz_err, res_op, res_data}
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp_data;
    logic        exp_en;
    logic        exp_divz;
  } vec_t;

  vec_t vecs[13];

  alu32_issue_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_en    (alu_en),
    .alu_op    (alu_op),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .divz_err  (divz_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model (combinational, external to the DUT) ------
  function automatic logic [32:0] alu_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      5'b00000: return {1'b0, a} + {1'b0, b};
      5'b00001: return {1'b0, a} - {1'b0, b};
      5'b00010: return {1'b0, a} + 33'd1;
      5'b00100: return {1'b0, a} - 33'd1;
      5'b01000: return {1'b0, a & b};
      5'b00011: return {1'b0, a | b};
      5'b11000: return {1'b0, a ^ b};
      5'b00110: return {1'b0, ~a};
      5'b00101: return (b == 32'd0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
      5'b01010: return {1'b0, a} << b[4:0];
      default:  return 33'h1_5555_5555;
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_op, alu_in1, alu_in2);

  function automatic logic is_defined(logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
      5'b00011, 5'b11000, 5'b00110, 5'b00101, 5'b01010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected result register contents for one command.
  function automatic logic [38:0] exp_res(logic [4:0] op, logic [31:0] a, logic [31:0] b);
`ifdef ALU_DIVZ_TRAP_EN
    if (op == 5'b00101 && b == 32'd0) return {1'b1, op, 33'h1_FFFF_FFFF};
`endif
    if (!is_defined(op)) return {1'b0, op, 33'd0};
    return {1'b0, op, alu_model(op, a, b)};
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %h expected none at %0t", {divz_err, res_op, res_data}, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_order", {25'd0, divz_err, res_op, res_data}, {25'd0, mon_e});
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push_cmd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    exp_q.push_back(exp_res(op, a, b));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [38:0] held;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 5'd0;
    cmd_a = 32'd0;
    cmd_b = 32'd0;
    res_ready = 1'b1;

    vecs[0]  = '{5'b00000, 32'd5,          32'd7,          33'h0_0000_000C, 1'b1, 1'b0};
    vecs[1]  = '{5'b00001, 32'd0,          32'd1,          33'h1_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2]  = '{5'b00010, 32'hFFFF_FFFF,  32'd0,          33'h1_0000_0000, 1'b1, 1'b0};
    vecs[3]  = '{5'b00100, 32'd0,          32'd0,          33'h1_FFFF_FFFF, 1'b1, 1'b0};
    vecs[4]  = '{5'b01000, 32'hF0F0_F0F0,  32'hFF00_FF00,  33'h0_F000_F000, 1'b1, 1'b0};
    vecs[5]  = '{5'b00011, 32'h0F0F_0000,  32'h0000_00F0,  33'h0_0F0F_00F0, 1'b1, 1'b0};
    vecs[6]  = '{5'b11000, 32'hFFFF_0000,  32'h0FF0_0FF0,  33'h0_F00F_0FF0, 1'b1, 1'b0};
    vecs[7]  = '{5'b00110, 32'h1234_5678,  32'd0,          33'h0_EDCB_A987, 1'b1, 1'b0};
`ifdef ALU_DIVZ_TRAP_EN
    vecs[8]  = '{5'b00101, 32'd9,          32'd0,          33'h1_FFFF_FFFF, 1'b0, 1'b1};
`else
    vecs[8]  = '{5'b00101, 32'd9,          32'd0,          33'h0_FFFF_FFFF, 1'b1, 1'b0};
`endif
    vecs[9]  = '{5'b00101, 32'd9,          32'd3,          33'h0_0000_0003, 1'b1, 1'b0};
    vecs[10] = '{5'b01010, 32'h8000_0001,  32'd1,          33'h1_0000_0002, 1'b1, 1'b0};
    vecs[11] = '{5'b10101, 32'd3,          32'd4,          33'h0_0000_0000, 1'b1, 1'b0};
    vecs[12] = '{5'b00000, 32'hFFFF_FFFF,  32'd1,          33'h1_0000_0000, 1'b1, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_alu_en",    {63'd0, alu_en}, 64'd0);
    chk("rst_alu_op",    {59'd0, alu_op}, 64'd0);
    chk("rst_alu_in1",   {32'd0, alu_in1}, 64'd0);
    chk("rst_alu_in2",   {32'd0, alu_in2}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_data",  {31'd0, res_data}, 64'd0);
    chk("rst_res_op",    {59'd0, res_op}, 64'd0);
    chk("rst_divz_err",  {63'd0, divz_err}, 64'd0);

    // table: one command at a time, checking latency and issue signals
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = vecs[i].op;
      cmd_a     = vecs[i].a;
      cmd_b     = vecs[i].b;
      exp_q.push_back({vecs[i].exp_divz, vecs[i].op, vecs[i].exp_data});
      @(negedge clk);
      chk("vec_idle_valid", {63'd0, res_valid}, 64'd0);
      chk("vec_idle_divz",  {63'd0, divz_err}, 64'd0);
      chk("vec_cmd_ready",  {63'd0, cmd_ready}, 64'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("vec_alu_en",  {63'd0, alu_en}, {63'd0, vecs[i].exp_en});
      chk("vec_alu_op",  {59'd0, alu_op}, vecs[i].exp_en ? {59'd0, vecs[i].op} : 64'd0);
      chk("vec_alu_in1", {32'd0, alu_in1}, vecs[i].exp_en ? {32'd0, vecs[i].a} : 64'd0);
      chk("vec_alu_in2", {32'd0, alu_in2}, vecs[i].exp_en ? {32'd0, vecs[i].b} : 64'd0);
      chk("vec_pre_valid", {63'd0, res_valid}, 64'd0);
      @(negedge clk);
      chk("vec_res_valid", {63'd0, res_valid}, 64'd1);
      chk("vec_res_data",  {31'd0, res_data}, {31'd0, vecs[i].exp_data});
      chk("vec_res_op",    {59'd0, res_op}, {59'd0, vecs[i].op});
      chk("vec_divz_err",  {63'd0, divz_err}, {63'd0, vecs[i].exp_divz});
      chk("vec_alu_idle",  {63'd0, alu_en}, 64'd0);
    end

    // back-pressure: 1 held + DEPTH queued, then drain at one per cycle
    @(posedge clk);
    #1 res_ready = 1'b0;
    push_cmd(5'b00000, 32'd1, 32'd1);
    push_cmd(5'b00001, 32'd5, 32'd3);
    push_cmd(5'b11000, 32'hAAAA_AAAA, 32'h5555_5555);
    push_cmd(5'b00010, 32'd41, 32'd0);
    push_cmd(5'b00100, 32'd100, 32'd0);
    held = exp_res(5'b00000, 32'd1, 32'd1);
    @(negedge clk);
    chk("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
    chk("bp_res_data",  {31'd0, res_data}, {31'd0, held[32:0]});
    chk("bp_alu_en",    {63'd0, alu_en}, 64'd0);
    repeat (3) @(negedge clk);
    chk("bp_stable_data", {31'd0, res_data}, {31'd0, held[32:0]});
    chk("bp_stable_op",   {59'd0, res_op}, {59'd0, held[37:33]});
    @(posedge clk);
    #1 res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("drain_valid", {63'd0, res_valid}, 64'd1);
    end
    @(negedge clk);
    chk("drain_done",  {63'd0, res_valid}, 64'd0);
    chk("drain_ready", {63'd0, cmd_ready}, 64'd1);

    // streaming: back-to-back results in command order
    @(posedge clk);
    #1;
    push_cmd(5'b00001, 32'd0, 32'd1);
    push_cmd(5'b00010, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    chk("stream_r1_valid", {63'd0, res_valid}, 64'd1);
    chk("stream_r1_data",  {31'd0, res_data}, {31'd0, 33'h1_FFFF_FFFF});
    @(negedge clk);
    chk("stream_r2_valid", {63'd0, res_valid}, 64'd1);
    chk("stream_r2_data",  {31'd0, res_data}, {31'd0, 33'h1_0000_0000});
    @(negedge clk);
    chk("stream_idle", {63'd0, res_valid}, 64'd0);

    // reset with a held result and three queued commands
    @(posedge clk);
    #1 res_ready = 1'b0;
    push_cmd(5'b00000, 32'd10, 32'd20);
    push_cmd(5'b00000, 32'd11, 32'd21);
    push_cmd(5'b00000, 32'd12, 32'd22);
    push_cmd(5'b00000, 32'd13, 32'd23);
    @(negedge clk);
    chk("prerst_valid", {63'd0, res_valid}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("mrst_res_data",  {31'd0, res_data}, 64'd0);
    chk("mrst_alu_en",    {63'd0, alu_en}, 64'd0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mrst_no_stale", {63'd0, res_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    push_cmd(5'b00000, 32'd5, 32'd7);
    repeat (4) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu32_issue_queue.md
# alu32_issue_queue

Command buffer and result register placed directly upstream of the 32-bit combinational ALU. It accepts ALU commands (opcode plus two operands) over a valid/ready handshake and holds them in a small FIFO. It issues one command per cycle to the ALU, registers the ALU result, and presents it downstream over a second valid/ready handshake. This gives the purely combinational ALU a registered, back-pressurable pipeline interface.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept
- cmd_op  in  5  ALU opcode
- cmd_a  in  32  operand 1
- cmd_b  in  32  operand 2
- alu_en  out  1  ALU enable; high only in an issue cycle
- alu_op  out  5  opcode to ALU
- alu_in1  out  32  operand 1 to ALU
- alu_in2  out  32  operand 2 to ALU
- alu_out  in  33  ALU result, combinational from alu_*
- res_valid  out  1  result register full
- res_ready  in  1  downstream accepts result
- res_data  out  33  registered result; MSB is carry/borrow
- res_op  out  5  opcode that produced res_data
- divz_err  out  1  qualifies res_data; see Configuration

## Operation
- Push: cmd_valid && cmd_ready writes {cmd_op, cmd_a, cmd_b} at the tail.
- cmd_ready = !full. No write-through when full, even if a pop occurs in the same cycle.
- Issue condition: FIFO non-empty && (!res_valid || res_ready).
- Issue cycle:
  - alu_en=1; alu_op/alu_in1/alu_in2 driven from the head entry.
  - Head popped at the clock edge.
  - res_data ← alu_out, res_op ← head op, res_valid ← 1.
- Non-issue cycle:
  - alu_en=0 and alu_op/alu_in1/alu_in2 = 0.
  - If res_valid && res_ready, res_valid ← 0.
  - Otherwise res_* hold.
- Defined opcodes:
  - 00000 add, 00001 sub, 00010 inc, 00100 dec, 01000 and, 00011 or, 11000 xor, 00110 not, 00101 div, 01010 shift.
- Undefined opcode:
  - Still issued, with alu_en=1.
  - res_data forced to 33'h0 instead of alu_out; res_op carries the raw code.
- Simultaneous push and issue in the same cycle: both take effect; occupancy count unchanged.
- Pointers wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits wide.
- Result order equals command order. No reordering, no drops (except as described under Configuration).

## Timing
- Reset values:
  - cmd_ready=1, alu_en=0, alu_op=0, alu_in1=0, alu_in2=0.
  - res_valid=0, res_data=0, res_op=0, divz_err=0.
  - FIFO empty.
- Reset mid-operation: every queued command and any held result is discarded in the reset cycle. No result is emitted for them.
- Latency: a command accepted at edge N is issued in cycle N+1 (when the queue was empty and no stall). res_valid is high after edge N+1, i.e. 2 cycles from handshake to result.
- Throughput: 1 result per cycle while res_ready=1 and commands keep arriving.
- Back-pressure:
  - res_valid=1 && res_ready=0 blocks issue; res_* stable.
  - The queue fills, then cmd_ready drops the cycle after the DEPTH-th accept.
- res_valid rises and falls only on clock edges. res_data/res_op change only in issue cycles.

## Configuration
- ALU_DIVZ_TRAP_EN
  - Defined:
    - A head entry with op=00101 and operand 2 = 0 is not issued: alu_en stays 0 in that cycle.
    - It is still popped under the normal issue condition.
    - It loads res_data=33'h1_FFFF_FFFF, res_op=00101, divz_err=1.
    - divz_err follows the result register: cleared when the next result loads, or when the result is consumed with no new issue.
  - Undefined:
    - Divide-by-zero is issued like any other op and res_data = alu_out.
    - divz_err tied to 0.

## Test plan
- Reset, then push add a=5, b=7 with res_ready=1 → alu_en one cycle later; res_valid 2 cycles after handshake; res_data=33'h0_0000_000C, res_op=00000.
- Hold res_ready=0, push 5 commands with DEPTH=4 → 1 result held, 4 queued; cmd_ready=0 after the 5th accept; release res_ready → 5 results in order at 1/cycle.
- Continuous push plus drain of sub a=0, b=1 then inc a=32'hFFFF_FFFF → results arrive back-to-back, each equal to the ALU's 33-bit output for that command, in command order.
- Push opcode 10101 a=3, b=4 → res_data=0, res_op=10101, alu_en pulsed once.
- With ALU_DIVZ_TRAP_EN: push div a=9, b=0 then div a=9, b=3 → first result 33'h1_FFFF_FFFF with divz_err=1 and no alu_en for it; second result 33'h3 with divz_err=0.
- Assert rst for 1 cycle with 3 commands queued and a result held → res_valid=0, cmd_ready=1 next cycle; no stale result ever emitted.
